lsu_mem_requester: RTL and testbench

- Pipeline-side initiator for the MMU word-memory protocol (mem_valid/mem_we/mem_addr/mem_w_data out; mem_r_data/mem_ready in).
- Converts RV32 load/store ops (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned MMU transactions.
- Sub-word stores use read-modify-write, because the MMU only writes full words.
- Sits between the execute/memory pipeline stage and the MMU, and provides the stall handshake.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_lane_unit.sv | 26 ++
 rtl/lsu_mem_requester.sv | 137 +++++++++++++
 tb/tb_lsu_mem_requester.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and legality helpers for the LSU requester.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT} state_t;
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: byte/half lane extract-and-extend for loads and lane merge for sub-word stores.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  always_comb begin
    sh     = (funct3[1:0] == 2'b01) ? {off[1], 4'b0000} : {off, 3'b000};
    lane   = word >> sh;
    rdata  = funct3 == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
             funct3 == F3_BU ? {24'b0, lane[7:0]} :
             funct3 == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
             funct3 == F3_HU ? {16'b0, lane[15:0]} : word;
    mask   = funct3 == F3_B ? 32'h0000_00FF << sh :
             funct3 == F3_H ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    merged = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/lsu_mem_requester.sv
// lsu_mem_requester: turns RV32 load/store ops into word-aligned MMU transactions,
// using read-modify-write for sub-word stores, with a per-wait-state timeout.
module lsu_mem_requester
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  input  logic                  mem_ready
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t                state_q, state_d;
  logic                  rmw_q, rmw_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_w_data_q, mem_w_data_d;
  logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [DATA_WIDTH-1:0] load_data, merged_data;
  logic                  timeout_hit, req_bad;
  lsu_lane_unit u_lane (
    .word   (mem_r_data),
    .off    (off_q),
    .funct3 (f3_q),
    .wdata  (wdata_q),
    .rdata  (load_data),
    .merged (merged_data)
  );
  always_comb begin
    timeout_hit  = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    req_bad      = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    state_d      = state_q;
    rmw_d        = rmw_q;
    off_d        = off_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    timer_d      = timer_q + TW'(1);
    mem_valid_d  = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    if (state_q == S_IDLE) begin
      if (req_valid && req_bad) begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end else if (req_valid) begin
        rmw_d       = req_we && req_funct3 != F3_W;
        off_d       = req_addr[1:0];
        f3_d        = req_funct3;
        wdata_d     = req_wdata;
        timer_d     = '0;
        mem_valid_d = 1'b1;
        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_we_d    = req_we && req_funct3 == F3_W;
        state_d     = mem_we_d ? S_WR_WAIT : S_RD_WAIT;
        mem_w_data_d = mem_we_d ? req_wdata : mem_w_data_q;
      end
    end else if (mem_ready && state_q == S_RD_WAIT && rmw_q) begin
      state_d      = S_WR_WAIT;
      timer_d      = '0;
      mem_valid_d  = 1'b1;
      mem_we_d     = 1'b1;
      mem_w_data_d = merged_data;
    end else if (mem_ready) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b1;
      resp_rdata_d = (state_q == S_RD_WAIT) ? load_data : '0;
    end else if (timeout_hit) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rmw_q        <= 1'b0;
      off_q        <= '0;
      f3_q         <= '0;
      wdata_q      <= '0;
      timer_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rmw_q        <= rmw_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      timer_q      <= timer_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign req_ready  = state_q == S_IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_w_data = mem_w_data_q;
endmodule

// File: tb/tb_lsu_mem_requester.sv
// tb_lsu_mem_requester: directed vector table plus hand sequences for timeout,
// back-to-back, stray responses and mid-op reset, against a delay-programmable MMU stub.
module tb_lsu_mem_requester;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_we, mem_ready = 0;
  logic [31:0] mem_addr, mem_w_data, mem_r_data = 0;
  int n_checks = 0, n_fail = 0;

  lsu_mem_requester #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .mem_ready(mem_ready));

  always #5 clk = ~clk;

  // MMU stub: responds 'dly' cycles after the mem_valid cycle unless disabled
  logic [31:0] mem [0:255];
  int          dly = 1, cnt = 0, n_pulses = 0;
  logic        pend = 0, stub_en = 1, stray_pulse = 0, p_we = 0;
  logic [31:0] p_addr = 0, p_wd = 0, last_addr = 0, last_wr = 0;
  always @(negedge clk) begin
    mem_ready = 0;
    if (stray_pulse) begin
      mem_ready = 1;
      stray_pulse = 0;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 0;
        if (stub_en) begin
          mem_ready = 1;
          if (p_we) mem[p_addr[9:2]] = p_wd;
          else mem_r_data = mem[p_addr[9:2]];
        end
      end
    end
    if (mem_valid) begin
      pend = 1; cnt = dly; p_we = mem_we; p_addr = mem_addr; p_wd = mem_w_data;
      n_pulses++;
      last_addr = mem_addr;
      if (mem_we) last_wr = mem_w_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called just after a negedge; returns at the negedge of the resp_valid cycle
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    if (!resp_valid) lat = -1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          dly;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat, exp_pulses;
    logic [31:0] exp_wr;
  } vec_t;
  vec_t v[17];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, seen;
    v[0]  = '{0, 3'b000, 32'h103, 32'h0,        1, 32'hFFFF_FF80, 0, 3, 1, 32'h0};
    v[1]  = '{0, 3'b100, 32'h103, 32'h0,        1, 32'h0000_0080, 0, 3, 1, 32'h0};
    v[2]  = '{0, 3'b001, 32'h102, 32'h0,        1, 32'hFFFF_8081, 0, 3, 1, 32'h0};
    v[3]  = '{0, 3'b010, 32'h100, 32'h0,        1, 32'h8081_7F02, 0, 3, 1, 32'h0};
    v[4]  = '{0, 3'b101, 32'h100, 32'h0,        1, 32'h0000_7F02, 0, 3, 1, 32'h0};
    v[5]  = '{0, 3'b000, 32'h100, 32'h0,        1, 32'h0000_0002, 0, 3, 1, 32'h0};
    v[6]  = '{1, 3'b000, 32'h202, 32'h1234_56AB, 1, 32'h0,         0, 5, 2, 32'h11AB_3344};
    v[7]  = '{1, 3'b010, 32'h200, 32'hDEAD_BEEF, 1, 32'h0,         0, 3, 1, 32'hDEAD_BEEF};
    v[8]  = '{1, 3'b001, 32'h202, 32'h0000_CAFE, 1, 32'h0,         0, 5, 2, 32'hCAFE_BEEF};
    v[9]  = '{0, 3'b010, 32'h101, 32'h0,        1, 32'h0,         1, 1, 0, 32'h0};
    v[10] = '{1, 3'b100, 32'h200, 32'h5,        1, 32'h0,         1, 1, 0, 32'h0};
    v[11] = '{0, 3'b001, 32'h101, 32'h0,        1, 32'h0,         1, 1, 0, 32'h0};
    v[12] = '{0, 3'b010, 32'h200, 32'h0,        3, 32'hCAFE_BEEF, 0, 5, 1, 32'h0};
    v[13] = '{0, 3'b010, 32'h100, 32'h0,        6, 32'h8081_7F02, 0, 8, 1, 32'h0};
    v[14] = '{1, 3'b000, 32'h201, 32'h0000_0055, 3, 32'h0,         0, 9, 2, 32'hCAFE_55EF};
    v[15] = '{0, 3'b011, 32'h100, 32'h0,        1, 32'h0,         1, 1, 0, 32'h0};
    v[16] = '{0, 3'b010, 32'h200, 32'h0,        1, 32'hCAFE_55EF, 0, 3, 1, 32'h0};
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8081_7F02;
    mem[8'h80] = 32'h1122_3344;
    #1;
    check("reset mem_valid", {31'b0, mem_valid}, 32'h0);
    check("reset resp_valid", {31'b0, resp_valid}, 32'h0);
    check("reset outputs", {mem_we, resp_err} | mem_addr | mem_w_data | resp_rdata, 32'h0);
    check("reset req_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      dly = v[i].dly; n_pulses = 0; last_wr = 0;
      check($sformatf("v%0d req_ready", i), {31'b0, req_ready}, 32'h1);
      run_op(v[i].we, v[i].f3, v[i].addr, v[i].wd, rd, er, lat);
      check($sformatf("v%0d rdata", i), rd, v[i].exp_rd);
      check($sformatf("v%0d err", i), {31'b0, er}, {31'b0, v[i].exp_err});
      check($sformatf("v%0d latency", i), lat, v[i].exp_lat);
      check($sformatf("v%0d mem pulses", i), n_pulses, v[i].exp_pulses);
      if (v[i].exp_pulses != 0)
        check($sformatf("v%0d mem_addr", i), last_addr, {v[i].addr[31:2], 2'b00});
      if (v[i].we && !v[i].exp_err)
        check($sformatf("v%0d write word", i), last_wr, v[i].exp_wr);
      @(negedge clk);
    end

    // timeout on a load, then a stray mem_ready while idle
    stub_en = 0; dly = 1; n_pulses = 0;
    run_op(0, 3'b010, 32'h100, 32'h0, rd, er, lat);
    check("timeout latency", lat, 9);
    check("timeout err", {31'b0, er}, 32'h1);
    stray_pulse = 1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    check("stray ready no resp", seen, 0);
    // RMW read phase timeout issues no write
    n_pulses = 0;
    run_op(1, 3'b000, 32'h200, 32'h77, rd, er, lat);
    check("rmw timeout err", {31'b0, er}, 32'h1);
    check("rmw timeout pulses", n_pulses, 1);
    check("rmw timeout mem intact", mem[8'h80], 32'hCAFE_55EF);
    stub_en = 1;
    @(negedge clk); @(negedge clk);

    // back-to-back: next op accepted in the resp_valid cycle
    dly = 1;
    run_op(0, 3'b010, 32'h100, 32'h0, rd, er, lat);
    check("b2b first data", rd, 32'h8081_7F02);
    check("b2b req_ready in resp cycle", {31'b0, req_ready}, 32'h1);
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("b2b mem_valid next cycle", {31'b0, mem_valid}, 32'h1);
    check("b2b mem_addr", mem_addr, 32'h200);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b second data", resp_rdata, 32'hCAFE_55EF);
    check("b2b second latency", lat, 3);
    @(negedge clk);

    // reset during S_WR_WAIT, then a stale mem_ready arrives
    dly = 6;
    req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("midop mem_valid", {31'b0, mem_valid & mem_we}, 32'h1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("midop rst outputs", {mem_valid, mem_we, resp_valid, resp_err} | mem_addr | mem_w_data | resp_rdata, 32'h0);
    check("midop rst req_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    check("stale ready after reset", seen, 0);
    check("req_ready after reset", {31'b0, req_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
